adder_subtractor_seq: RTL
=========================

Name: adder_subtractor_seq

Overview:
Parametrised, multi-cycle add/subtract engine. It is the next generation of the team's fixed 8-bit adder_subtractor. Operands of WIDTH bits are processed CHUNK bits per clock through one shared chunk adder, so a single small adder serves wide datapaths such as the mantissa/exponent paths of the 32-bit FP adder. It adds valid/ready handshakes on both sides, a global enable and a full flag set (carry, signed overflow, zero, negative).

Parameters:
WIDTH, 32, operand/result width in bits.
CHUNK, 8, bits processed per cycle; must divide WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  1 = accept inputs and advance computation; 0 = freeze.
in_valid  in  1  operands and ctl valid.
in_ready  out  1  engine can accept an operation.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
ctl  in  1  0 = A+B, 1 = A-B.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer takes the result.
result  out  WIDTH  sum or difference, modulo 2^WIDTH.
cout  out  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned).
ovf  out  1  two's-complement signed overflow.
zero  out  1  result == 0.
neg  out  1  result[WIDTH-1].

Behaviour:
- Reset (async assert, sync release): state IDLE. out_valid, result, cout, ovf, zero, neg, chunk counter, carry and operand registers all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = enable (combinational from state).
  - Accept on clk edge with in_valid & in_ready: latch A, B' = ctl ? ~B : B, carry = ctl, cnt = 0. Go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge with enable = 1: {c, s} = A[cnt] + B'[cnt] + carry, where A[cnt] and B'[cnt] are CHUNK-wide slices, LSB chunk first.
  - Write s into result slice cnt; carry <= c; cnt++.
  - On the edge processing cnt = NCHUNK-1, register all flags and go to DONE:
    - cout = c.
    - ovf = (A msb == B' msb) & (result msb != A msb).
    - zero = (full result == 0).
    - neg = result msb.
  - enable = 0: all state holds, no progress.
- DONE:
  - out_valid = 1 (registered). result and flags are stable.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE.
  - enable has no effect on the output handshake.
- Latency: out_valid rises NCHUNK enabled edges after the accept edge. Throughput is one op per NCHUNK+2 cycles, counting one IDLE bubble after each consume.
- result/flags during RUN: result bits hold partial values, and consumers ignore them while out_valid = 0. Flags keep their previous values until the final chunk.
- Boundary conditions:
  - in_valid held during RUN/DONE: not accepted. Operands may change freely while in_ready = 0.
  - in_valid & out_ready in the same DONE cycle: only the consume happens. The new op is accepted in IDLE next cycle.
  - rst_n low mid-RUN or in DONE: operation aborted, no result delivered, outputs return to reset values immediately.
  - NCHUNK = 1: single-cycle RUN. Flags and counter still behave as above.
  - Subtract of equal operands: result 0, zero = 1, cout = 1.

Decomposition:
- Package adder_seq_pkg:
  - CTL_ADD = 1'b0, CTL_SUB = 1'b1.
  - State enum {IDLE, RUN, DONE}.
  - Function computing the counter width, clog2(NCHUNK) with a minimum of 1.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder with ports a, b, cin, sum, cout. It is instantiated once and reused every RUN cycle.
- Top level holds the FSM, operand/result shift-free slice registers, counter and flag logic.

Test Plan:
- WIDTH=8, CHUNK=4, enable=1, 28+34 (ctl=0) -> result 62 (0x3E), cout=0, ovf=0, zero=0, neg=0; out_valid exactly 2 cycles after the accept edge.
- WIDTH=8, CHUNK=4:
  - 255+34 -> result 0x21, cout=1, ovf=0.
  - 127+1 -> result 0x80, ovf=1, neg=1, cout=0.
- WIDTH=8, CHUNK=4, subtract:
  - 28-34 -> 0xFA, cout=0, neg=1.
  - 22-22 -> 0x00, zero=1, cout=1.
  - 1-0 -> 0x01.
  - 0-1 -> 0xFF, cout=0.
- Defaults (32/8), 0x7FFF_FFFF+1 with enable low for 3 cycles mid-RUN -> out_valid after 4+3 cycles; result 0x8000_0000, ovf=1. With enable low in IDLE, in_valid is ignored and in_ready=0.
- Defaults: hold out_ready=0 for 5 cycles in DONE -> result/flags/out_valid stable. in_valid held high during that time is not accepted. After consume, next op is accepted one cycle later.
- Defaults: assert rst_n low during RUN chunk 2 -> out_valid=0 and result=0 immediately. After release, in_ready=1 in IDLE and a new op completes correctly.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the sequential add/subtract engine: control encoding,
// FSM state type and counter sizing.
package adder_seq_pkg;

  localparam logic CTL_ADD = 1'b0;
  localparam logic CTL_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-chunk datapath still needs a 1-bit counter to keep ports legal.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; the top reuses one instance for
// every slice of a wide operation.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] w_carry;

  always_comb begin
    sum        = '0;
    w_carry    = '0;
    w_carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
    cout = w_carry[CHUNK];
  end

endmodule

// File: rtl/adder_subtractor_seq.sv
// Multi-cycle WIDTH-bit add/subtract engine: one CHUNK-bit adder walks the
// operands LSB chunk first, with valid/ready on both sides and a full flag set.
//
//   state | meaning
//   IDLE  | waiting for an operation; in_ready follows enable
//   RUN   | one chunk per enabled clock, carry chained through r_carry
//   DONE  | result and flags presented until out_ready
module adder_subtractor_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_carry_out;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_consume;

  assign in_ready  = (r_state == IDLE) && enable;
  assign w_accept  = in_valid && in_ready;
  assign w_step    = (r_state == RUN) && enable;
  assign w_last    = w_step && (r_cnt == LAST_CNT);
  assign w_consume = (r_state == DONE) && out_ready;

  assign w_a_chunk = r_a[int'(r_cnt)*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[int'(r_cnt)*CHUNK +: CHUNK];

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_carry_out)
  );

  // Flags on the last chunk are taken from the result as it will be written.
  always_comb begin
    w_result_next = r_result;
    w_result_next[int'(r_cnt)*CHUNK +: CHUNK] = w_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      // Subtraction is A + ~B + 1: invert B once here and seed the carry.
      if (w_accept) begin
        r_a     <= a;
        r_b     <= (ctl == CTL_SUB) ? ~b : b;
        r_carry <= (ctl == CTL_SUB);
        r_cnt   <= '0;
      end
      if (w_step) begin
        r_result <= w_result_next;
        r_carry  <= w_carry_out;
        if (w_last) begin
          r_cnt       <= '0;
          r_cout      <= w_carry_out;
          r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                         (w_result_next[WIDTH-1] != r_a[WIDTH-1]);
          r_zero      <= (w_result_next == '0);
          r_neg       <= w_result_next[WIDTH-1];
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule
